bus_memory_responder: RTL and testbench

Memory-side responder for the CPU's multiplexed 16-bit address/data bus. It watches the strobes generated by the bus interface unit (ale, rd_, wr_, den_, dtr_), latches the address phase, and decodes the address against its window. Selected cycles access a local word-addressed RAM, with a configurable number of wait states signalled on ready. It sits on the system bus alongside other responders, and only drives the bus during a selected read.

---
 rtl/bus_memory_responder.sv | 138 +++++++++++++
 tb/tb_bus_memory_responder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_memory_responder.sv
// Memory-side responder for the multiplexed 16-bit address/data bus: latches the
// address phase, decodes a word window, and serves a local RAM with programmable wait states.
module bus_memory_responder #(
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int          ADDR_W      = 6,
  parameter int          WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        ale,
  input  logic        rd_,
  input  logic        wr_,
  input  logic        den_,
  input  logic        dtr_,
  input  logic [15:0] ad_in,
  output logic [15:0] ad_out,
  output logic        ad_oe,
  output logic        ready,
  output logic        bus_err
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_DATA, S_DONE} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_q_reg, addr_q_next;
  logic                sel_reg, sel_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic                ready_reg, ready_next;
  logic                bus_err_reg, bus_err_next;
  logic                mem_we;
  logic [15:0]         win_off;
  logic                win_hit;
  logic                dtr_bad;

  logic [15:0] mem [DEPTH];

  // Offset is taken modulo 2^16 so windows straddling 16'hFFFF decode correctly.
  assign win_off = ad_in - BASE_ADDR;
  assign win_hit = (win_off >> ADDR_W) == 16'd0;
  assign dtr_bad = (~rd_ & dtr_) | (~wr_ & ~dtr_);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_reg   <= S_IDLE;
      addr_q_reg  <= '0;
      sel_reg     <= 1'b0;
      cnt_reg     <= 4'd0;
      ready_reg   <= 1'b1;
      bus_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      addr_q_reg  <= addr_q_next;
      sel_reg     <= sel_next;
      cnt_reg     <= cnt_next;
      ready_reg   <= ready_next;
      bus_err_reg <= bus_err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    addr_q_next  = addr_q_reg;
    sel_next     = sel_reg;
    cnt_next     = cnt_reg;
    ready_next   = ready_reg;
    bus_err_next = 1'b0;
    mem_we       = 1'b0;
    if (ale) begin
      // A new address phase always wins and abandons whatever was in flight.
      addr_q_next = ad_in[ADDR_W-1:0];
      sel_next    = win_hit;
      state_next  = S_ADDR;
      ready_next  = 1'b1;
    end else if (state_reg != S_IDLE && !rd_ && !wr_) begin
      bus_err_next = 1'b1;
      state_next   = S_IDLE;
      ready_next   = 1'b1;
    end else begin
      case (state_reg)
        S_ADDR: begin
          if (!sel_reg) begin
            if (rd_ && wr_) state_next = S_IDLE;
          end else if (rd_ ^ wr_) begin
            if (dtr_bad) begin
              bus_err_next = 1'b1;
              state_next   = S_IDLE;
              ready_next   = 1'b1;
            end else if (WAIT_STATES > 0) begin
              state_next = S_WAIT;
              cnt_next   = CNT_INIT;
              ready_next = 1'b0;
            end else begin
              state_next = S_DATA;
            end
          end
        end
        S_WAIT: begin
          if (rd_ && wr_) begin
            state_next = S_IDLE;
            ready_next = 1'b1;
          end else if (cnt_reg == 4'd0) begin
            state_next = S_DATA;
            ready_next = 1'b1;
          end else begin
            cnt_next = cnt_reg - 4'd1;
          end
        end
        S_DATA: begin
          if (!wr_) begin
            if (!den_) begin
              mem_we     = 1'b1;
              state_next = S_DONE;
            end
          end else if (rd_) begin
            state_next = S_IDLE;
          end
        end
        S_DONE: begin
          if (wr_) state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q_reg] <= ad_in;
  end

  assign ad_out  = (state_reg == S_DATA) ? mem[addr_q_reg] : 16'h0000;
  assign ad_oe   = (state_reg == S_DATA) & ~rd_ & ~den_ & sel_reg;
  assign ready   = ready_reg;
  assign bus_err = bus_err_reg;

endmodule

// File: tb/tb_bus_memory_responder.sv
// Bench for bus_memory_responder: three instances (window 0x0100 with 2 and 0 waits,
// wrapping window at 0xFFF0) exercised by a CPU-like bus cycle task.
module tb_bus_memory_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  ale = '0, rd_n = '1, wr_n = '1, den_n = '1, dtr_n = '1;
  logic [15:0] ad_in [3];
  logic [15:0] ad_out [3];
  logic [2:0]  ad_oe, ready, bus_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bus_memory_responder #(.BASE_ADDR(16'h0100), .ADDR_W(6), .WAIT_STATES(2)) u0 (
    .clk(clk), .rst_(rst_n), .ale(ale[0]), .rd_(rd_n[0]), .wr_(wr_n[0]), .den_(den_n[0]),
    .dtr_(dtr_n[0]), .ad_in(ad_in[0]), .ad_out(ad_out[0]), .ad_oe(ad_oe[0]),
    .ready(ready[0]), .bus_err(bus_err[0]));

  bus_memory_responder #(.BASE_ADDR(16'h0100), .ADDR_W(6), .WAIT_STATES(0)) u1 (
    .clk(clk), .rst_(rst_n), .ale(ale[1]), .rd_(rd_n[1]), .wr_(wr_n[1]), .den_(den_n[1]),
    .dtr_(dtr_n[1]), .ad_in(ad_in[1]), .ad_out(ad_out[1]), .ad_oe(ad_oe[1]),
    .ready(ready[1]), .bus_err(bus_err[1]));

  bus_memory_responder #(.BASE_ADDR(16'hFFF0), .ADDR_W(6), .WAIT_STATES(2)) u2 (
    .clk(clk), .rst_(rst_n), .ale(ale[2]), .rd_(rd_n[2]), .wr_(wr_n[2]), .den_(den_n[2]),
    .dtr_(dtr_n[2]), .ad_in(ad_in[2]), .ad_out(ad_out[2]), .ad_oe(ad_oe[2]),
    .ready(ready[2]), .bus_err(bus_err[2]));

  typedef struct {
    int          u;
    logic [15:0] addr;
    bit          is_wr;
    logic [15:0] wdata;
    int          exp_waits;
    bit          exp_oe;
    logic [15:0] exp_data;
  } vec_t;

  typedef struct {
    int          waits;
    bit          oe;
    logic [15:0] rdata;
    bit          oe_after;
    bit          oe_early;
    bit          err_seen;
  } res_t;

  vec_t tbl[$];

  // Behavioural reference: per-unit word store plus knowledge of which words were written.
  logic [15:0] model_mem [3][64];
  bit          model_val [3][64];
  logic [15:0] unit_base [3] = '{16'h0100, 16'h0100, 16'hFFF0};
  int          unit_ws   [3] = '{2, 0, 2};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int u, input logic [15:0] a, input bit w, input logic [15:0] d,
                              input int ew, input bit eo, input logic [15:0] ed);
    vec_t v;
    v.u = u; v.addr = a; v.is_wr = w; v.wdata = d;
    v.exp_waits = ew; v.exp_oe = eo; v.exp_data = ed;
    return v;
  endfunction

  // Runs from the point where the strobe has just been driven low until the bus is idle again.
  task automatic finish_access(input int u, output res_t r);
    int guard;
    r.waits = 0; r.oe_early = 0; r.err_seen = 0; guard = 0;
    @(negedge clk);
    while (ready[u] == 1'b0 && guard < 40) begin
      r.waits++;
      r.oe_early |= ad_oe[u];
      r.err_seen |= bus_err[u];
      @(negedge clk);
      guard++;
    end
    r.oe = ad_oe[u];
    r.rdata = ad_out[u];
    r.err_seen |= bus_err[u];
    @(negedge clk);
    rd_n[u] = 1'b1; wr_n[u] = 1'b1; den_n[u] = 1'b1;
    #1 r.oe_after = ad_oe[u];
    @(negedge clk);
    r.err_seen |= bus_err[u];
  endtask

  task automatic bus_cycle(input int u, input logic [15:0] addr, input bit is_wr,
                           input logic [15:0] wdata, output res_t r);
    @(negedge clk);
    ale[u] = 1'b1; ad_in[u] = addr; dtr_n[u] = is_wr;
    rd_n[u] = 1'b1; wr_n[u] = 1'b1; den_n[u] = 1'b1;
    @(negedge clk);
    ale[u] = 1'b0; den_n[u] = 1'b0;
    if (is_wr) begin
      wr_n[u] = 1'b0; ad_in[u] = wdata;
    end else begin
      rd_n[u] = 1'b0; ad_in[u] = 16'h0000;
    end
    finish_access(u, r);
    $display("txn u=%0d addr=%h %s wdata=%h waits=%0d oe=%0d rdata=%h", u, addr,
             is_wr ? "WR" : "RD", wdata, r.waits, r.oe, r.rdata);
  endtask

  task automatic check_result(input string tag, input res_t r, input int ew, input bit eo,
                              input bit chk_data, input logic [15:0] ed);
    check({tag, " waits"}, r.waits, ew);
    check({tag, " oe"}, {31'd0, r.oe}, {31'd0, eo});
    if (chk_data) check({tag, " data"}, {16'd0, r.rdata}, {16'd0, ed});
    check({tag, " oe_release"}, {31'd0, r.oe_after}, 32'd0);
    check({tag, " oe_wait"}, {31'd0, r.oe_early}, 32'd0);
    check({tag, " bus_err"}, {31'd0, r.err_seen}, 32'd0);
  endtask

  initial begin
    res_t r;
    for (int i = 0; i < 3; i++) ad_in[i] = 16'h0000;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 64; j++) model_val[i][j] = 0;

    // Reset values, async assertion between clock edges
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset ready u%0d", i), {31'd0, ready[i]}, 32'd1);
      check($sformatf("reset bus_err u%0d", i), {31'd0, bus_err[i]}, 32'd0);
      check($sformatf("reset ad_oe u%0d", i), {31'd0, ad_oe[i]}, 32'd0);
      check($sformatf("reset ad_out u%0d", i), {16'd0, ad_out[i]}, 32'd0);
    end
    rst_n = 1'b1;

    // Directed table: expected values taken straight from the window/wait rules
    tbl.push_back(mk(0, 16'h0100, 1, 16'h1111, 2, 0, 16'h0000));
    tbl.push_back(mk(0, 16'h0105, 1, 16'hBEEF, 2, 0, 16'h0000));
    tbl.push_back(mk(0, 16'h0105, 0, 16'h0000, 2, 1, 16'hBEEF));
    tbl.push_back(mk(0, 16'h0200, 1, 16'hDEAD, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 16'h0200, 0, 16'h0000, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 16'h0100, 0, 16'h0000, 2, 1, 16'h1111));
    tbl.push_back(mk(1, 16'h0130, 1, 16'hCAFE, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 16'h0130, 0, 16'h0000, 0, 1, 16'hCAFE));
    tbl.push_back(mk(2, 16'h0010, 1, 16'hA5A5, 2, 0, 16'h0000));
    tbl.push_back(mk(2, 16'h0040, 1, 16'h5A5A, 0, 0, 16'h0000));
    tbl.push_back(mk(2, 16'hFFF0, 1, 16'h1357, 2, 0, 16'h0000));
    tbl.push_back(mk(2, 16'h002F, 1, 16'h2468, 2, 0, 16'h0000));
    tbl.push_back(mk(2, 16'h0030, 0, 16'h0000, 0, 0, 16'h0000));
    tbl.push_back(mk(2, 16'h0010, 0, 16'h0000, 2, 1, 16'hA5A5));
    tbl.push_back(mk(2, 16'hFFF0, 0, 16'h0000, 2, 1, 16'h1357));
    tbl.push_back(mk(2, 16'h002F, 0, 16'h0000, 2, 1, 16'h2468));
    tbl.push_back(mk(2, 16'h0040, 0, 16'h0000, 0, 0, 16'h0000));

    foreach (tbl[i]) begin
      bus_cycle(tbl[i].u, tbl[i].addr, tbl[i].is_wr, tbl[i].wdata, r);
      check_result($sformatf("tbl%0d", i), r, tbl[i].exp_waits, tbl[i].exp_oe,
                   tbl[i].exp_oe, tbl[i].exp_data);
    end

    // Both strobes low together: one-cycle error pulse, memory untouched
    @(negedge clk);
    ale[0] = 1'b1; ad_in[0] = 16'h0105; dtr_n[0] = 1'b0;
    @(negedge clk);
    ale[0] = 1'b0; rd_n[0] = 1'b0; wr_n[0] = 1'b0; ad_in[0] = 16'h4444;
    @(negedge clk);
    check("dual strobe bus_err", {31'd0, bus_err[0]}, 32'd1);
    check("dual strobe ready", {31'd0, ready[0]}, 32'd1);
    rd_n[0] = 1'b1; wr_n[0] = 1'b1;
    @(negedge clk);
    check("dual strobe pulse end", {31'd0, bus_err[0]}, 32'd0);

    // Read strobe while dtr_ says write
    ale[0] = 1'b1; ad_in[0] = 16'h0105; dtr_n[0] = 1'b1;
    @(negedge clk);
    ale[0] = 1'b0; rd_n[0] = 1'b0;
    @(negedge clk);
    check("dtr mismatch bus_err", {31'd0, bus_err[0]}, 32'd1);
    rd_n[0] = 1'b1;
    @(negedge clk);
    check("dtr mismatch pulse end", {31'd0, bus_err[0]}, 32'd0);
    bus_cycle(0, 16'h0105, 0, 16'h0000, r);
    check_result("after err", r, 2, 1, 1, 16'hBEEF);

    // Reset asserted during the wait states of a write
    @(negedge clk);
    ale[0] = 1'b1; ad_in[0] = 16'h0105; dtr_n[0] = 1'b1;
    @(negedge clk);
    ale[0] = 1'b0; wr_n[0] = 1'b0; den_n[0] = 1'b0; ad_in[0] = 16'h1234;
    @(negedge clk);
    check("pre-reset ready", {31'd0, ready[0]}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid-reset ready", {31'd0, ready[0]}, 32'd1);
    check("mid-reset ad_oe", {31'd0, ad_oe[0]}, 32'd0);
    wr_n[0] = 1'b1; den_n[0] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    bus_cycle(0, 16'h0105, 0, 16'h0000, r);
    check_result("after reset", r, 2, 1, 1, 16'hBEEF);

    // Write strobe released during wait states
    @(negedge clk);
    ale[0] = 1'b1; ad_in[0] = 16'h0105; dtr_n[0] = 1'b1;
    @(negedge clk);
    ale[0] = 1'b0; wr_n[0] = 1'b0; den_n[0] = 1'b0; ad_in[0] = 16'h7777;
    @(negedge clk);
    wr_n[0] = 1'b1; den_n[0] = 1'b1;
    @(negedge clk);
    check("abort ready", {31'd0, ready[0]}, 32'd1);
    check("abort bus_err", {31'd0, bus_err[0]}, 32'd0);
    bus_cycle(0, 16'h0105, 0, 16'h0000, r);
    check_result("after abort", r, 2, 1, 1, 16'hBEEF);

    // Back-to-back: ale on the same edge rd_ rises must start the next access
    @(negedge clk);
    ale[0] = 1'b1; ad_in[0] = 16'h0105; dtr_n[0] = 1'b0;
    @(negedge clk);
    ale[0] = 1'b0; rd_n[0] = 1'b0; den_n[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b first oe", {31'd0, ad_oe[0]}, 32'd1);
    check("b2b first data", {16'd0, ad_out[0]}, 32'h0000BEEF);
    rd_n[0] = 1'b1; den_n[0] = 1'b1; ale[0] = 1'b1; ad_in[0] = 16'h0100;
    @(negedge clk);
    ale[0] = 1'b0; rd_n[0] = 1'b0; den_n[0] = 1'b0;
    finish_access(0, r);
    check_result("b2b second", r, 2, 1, 1, 16'h1111);

    // Randomized traffic against the reference model
    for (int n = 0; n < 60; n++) begin
      int          u;
      logic [15:0] addr, wdata, off;
      bit          is_wr, hit;
      int          idx;
      u = ($urandom_range(0, 1) == 0) ? 0 : 2;
      addr = (u == 0) ? 16'(16'h00F0 + $urandom_range(0, 16'h60))
                      : 16'(16'hFFE0 + $urandom_range(0, 16'h70));
      is_wr = $urandom_range(0, 1) == 1;
      wdata = 16'($urandom);
      off = addr - unit_base[u];
      hit = off < 16'd64;
      idx = addr % 64;
      bus_cycle(u, addr, is_wr, wdata, r);
      check_result($sformatf("rand%0d", n), r, hit ? unit_ws[u] : 0, hit && !is_wr,
                   hit && !is_wr && model_val[u][idx], model_mem[u][idx]);
      if (hit && is_wr) begin
        model_mem[u][idx] = wdata;
        model_val[u][idx] = 1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
